// File: rtl/input_buffer_reader.sv
// Streams `length` buffer words from base_addr as valid/ready beats; first beat 2 cycles after start.
// A two-entry skid FIFO absorbs the read latency; reads stall once two words are outstanding.
module input_buffer_reader #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 4,
   parameter int RD_DATA_WIDTH = DATA_WIDTH,
   parameter int RD_ADDR_WIDTH = ADDR_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [RD_ADDR_WIDTH-1:0]        base_addr,
   input  logic [RD_ADDR_WIDTH:0]          length,
   output logic                            busy,
   output logic                            done,
   output logic                            rd_en,
   output logic [RD_ADDR_WIDTH-1:0]        rd_addr,
   input  logic signed [RD_DATA_WIDTH-1:0] rd_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic signed [RD_DATA_WIDTH-1:0] m_data,
   output logic                            m_last
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   localparam logic [RD_ADDR_WIDTH:0] ONE = 1;

   state_t                         state;
   logic [RD_ADDR_WIDTH-1:0]       base_q;
   logic [RD_ADDR_WIDTH:0]         len_q;
   logic [RD_ADDR_WIDTH:0]         iss;
   logic [RD_ADDR_WIDTH:0]         bt;
   logic                           infl;
   logic signed [RD_DATA_WIDTH-1:0] fifo_mem [2];
   logic                           wr_ptr;
   logic                           rd_ptr;
   logic [1:0]                     cnt;

   logic       pop;
   logic       fifo_pop;
   logic       push;
   logic [1:0] cnt_n;
   logic [2:0] occ_n;
   logic       issue_ok;

   // An in-flight word is presented straight from rd_data when the FIFO is empty,
   // and is only written into the FIFO if it is not taken in that same cycle.
   assign m_valid  = (cnt != 2'd0) || infl;
   assign m_data   = (cnt != 2'd0) ? fifo_mem[rd_ptr] : (infl ? rd_data : '0);
   assign m_last   = m_valid && (bt == (len_q - ONE));
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   assign pop      = m_valid && m_ready;
   assign fifo_pop = pop && (cnt != 2'd0);
   assign push     = infl && !(pop && (cnt == 2'd0));

   always_comb begin
      cnt_n = cnt;
      case ({push, fifo_pop})
         2'b10:   cnt_n = cnt + 2'd1;
         2'b01:   cnt_n = cnt - 2'd1;
         default: cnt_n = cnt;
      endcase
   end

   // Next-cycle occupancy: stored words plus the read currently on the bus.
   assign occ_n    = {1'b0, cnt_n} + {2'b00, rd_en};
   assign issue_ok = (iss < len_q) && (occ_n < 3'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         iss         <= '0;
         bt          <= '0;
         infl        <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         cnt         <= 2'd0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
      end else begin
         infl  <= rd_en;
         cnt   <= cnt_n;
         rd_en <= 1'b0;
         if (push) begin
            fifo_mem[wr_ptr] <= rd_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (fifo_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (pop) begin
            bt <= bt + ONE;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  len_q  <= length;
                  bt     <= '0;
                  if (length == '0) begin
                     iss   <= '0;
                     state <= DONE;
                  end else begin
                     rd_en   <= 1'b1;
                     rd_addr <= base_addr;
                     iss     <= ONE;
                     state   <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (iss == len_q) begin
                  state <= DRAIN;
               end else if (issue_ok) begin
                  rd_en   <= 1'b1;
                  rd_addr <= base_q + iss[RD_ADDR_WIDTH-1:0];
                  iss     <= iss + ONE;
               end
            end
            DRAIN: begin
               if (cnt_n == 2'd0) begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_buffer_reader.sv
// Bench for input_buffer_reader: table of transfers checked against a beat scoreboard, plus a reset sequence.
module tb_input_buffer_reader;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [3:0]          base_addr;
   logic [4:0]          length;
   logic                busy;
   logic                done;
   logic                rd_en;
   logic [3:0]          rd_addr;
   logic signed [15:0]  rd_data = '0;
   logic                m_valid;
   logic                m_ready;
   logic signed [15:0]  m_data;
   logic                m_last;

   int total = 0;
   int bad   = 0;

   logic signed [15:0] mem [16];
   logic signed [15:0] sb_dat [$];
   logic               sb_last [$];

   typedef struct {
      int          base;
      int          len;
      logic [15:0] rmask;
      int          pulse_c;
      int          exp_fv;
      int          exp_done;
   } vec_t;

   vec_t vt [8];

   input_buffer_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // Buffer model: registered read port; junk on the bus when not reading.
   always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'sh7EEF;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_xfer(input vec_t v);
      int c, fv, dn, nrd, nbt;
      logic hv, hl;
      logic signed [15:0] hd;
      fv = -1; dn = -1; nrd = 0; nbt = 0; hv = 1'b0; hl = 1'b0; hd = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'(v.base); length = 5'(v.len); m_ready = v.rmask[0];
      for (int i = 0; i < v.len; i++) begin
         sb_dat.push_back(mem[(v.base + i) % 16]);
         sb_last.push_back(i == v.len - 1);
      end
      c = 1;
      while (dn < 0 && c < 200) begin
         @(posedge clk); #1;
         start = (c == v.pulse_c); base_addr = 4'd9; length = 5'd3; m_ready = v.rmask[c % 16];
         @(negedge clk);
         if (c == 1) chk("busy_cycle1", busy, 1);
         if (rd_en) begin
            nrd++;
            chk("rd_addr", rd_addr, (v.base + nrd - 1) % 16);
         end
         chk("outstanding_le2", (nrd - nbt) <= 2, 1);
         if (hv) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, hd);
            chk("stall_last", m_last, hl);
         end
         if (m_valid && fv < 0) fv = c;
         if (m_valid && m_ready) begin
            nbt++;
            if (sb_dat.size() == 0) chk("extra_beat", nbt, v.len);
            else begin
               chk("beat_data", m_data, sb_dat.pop_front());
               chk("beat_last", m_last, sb_last.pop_front());
            end
         end
         hv = m_valid && !m_ready; hd = m_data; hl = m_last;
         if (done) dn = c;
         c++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      if (v.exp_done >= 0) chk("done_cycle", dn, v.exp_done);
      else chk("done_seen", dn > 0, 1);
      chk("first_valid_cycle", fv, v.exp_fv);
      chk("reads_issued", nrd, v.len);
      chk("beats_delivered", nbt, v.len);
      chk("scoreboard_left", sb_dat.size(), 0);
      sb_dat.delete();
      sb_last.delete();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 16'(k - 8);
      //        base len  m_ready mask  pulse fv  done
      vt[0] = '{4,   5,  16'hFFFF,     -1,   2,  7};
      vt[1] = '{14,  4,  16'hFFFF,     -1,   2,  6};
      vt[2] = '{4,   5,  16'hFFE3,     -1,   2,  10};
      vt[3] = '{0,   0,  16'hFFFF,     -1,   -1, 1};
      vt[4] = '{1,   6,  16'hFFFF,     3,    2,  8};
      vt[5] = '{0,   3,  16'hFFFF,     5,    2,  5};
      vt[6] = '{3,   16, 16'hFFFF,     -1,   2,  18};
      vt[7] = '{9,   7,  16'h6C35,     -1,   2,  -1};

      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_rd_addr", rd_addr, 0);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_data", m_data, 0);
      chk("reset_m_last", m_last, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_xfer(vt[i]);

      // Reset after the second beat of a 6-word transfer.
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd2; length = 5'd6; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_seq_beat1", m_data, -6);
      @(posedge clk);
      @(negedge clk);
      chk("rst_seq_beat2", m_data, -5);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rd_en", rd_en, 0);
      chk("midrst_rd_addr", rd_addr, 0);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_m_data", m_data, 0);
      chk("midrst_m_last", m_last, 0);
      repeat (2) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("postrst_no_done", done, 0);
         chk("postrst_idle", busy, 0);
      end
      run_xfer('{10, 3, 16'hFFFF, -1, 2, 5});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
